sync_fifo_flex: RTL and testbench

Single-clock, parametrised FIFO. It is the synchronous successor to the team's dual-clock FIFO_TOP, for blocks that share one clock domain.
Adds a fill-level output, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with clear.
Read port is selectable between first-word-fall-through (FWFT) and registered-read mode.
Sits between producer/consumer datapaths inside one clock domain.

---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_mem.sv | 27 ++
 rtl/sync_fifo_flex.sv | 125 ++++++++++++
 tb/tb_sync_fifo_flex.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and elaboration-time helpers for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  // Pointer/level width: address bits plus one wrap bit.
  function automatic int unsigned calc_p_size(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // True when n is a power of two and at least 2.
  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  // Thresholds must be ordered and within the FIFO capacity.
  function automatic bit thresh_ok(input int unsigned depth,
                                   input int unsigned ae,
                                   input int unsigned af);
    return (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array, synchronous write, asynchronous read.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word on an accepted write; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered read.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned P_SIZE     = calc_p_size(FIFO_DEPTH),
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned FWFT       = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [P_SIZE-1:0]     FILL_LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned AW = P_SIZE - 1;

  // Reject illegal configurations at elaboration.
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flex: FIFO_DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(FIFO_DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_flex: need AE_THRESH < AF_THRESH <= FIFO_DEPTH");
  end
  if (P_SIZE != calc_p_size(FIFO_DEPTH)) begin : g_bad_psize
    $error("sync_fifo_flex: P_SIZE must equal clog2(FIFO_DEPTH)+1");
  end

  logic [P_SIZE-1:0]     wr_ptr_q;
  logic [P_SIZE-1:0]     rd_ptr_q;
  logic [P_SIZE-1:0]     level;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  // Occupancy is the pointer distance; the wrap bit makes full and empty distinct.
  assign level        = wr_ptr_q - rd_ptr_q;
  assign FILL_LEVEL   = level;
  assign EMPTY        = (level == '0);
  assign FULL         = (level == P_SIZE'(FIFO_DEPTH));
  assign ALMOST_FULL  = (level >= P_SIZE'(AF_THRESH));
  assign ALMOST_EMPTY = (level <= P_SIZE'(AE_THRESH));
  assign OVERFLOW     = overflow_q;
  assign UNDERFLOW    = underflow_q;

  // Acceptance depends only on registered state, never on the opposite port.
  assign wr_acc = W_INC && !FULL;
  assign rd_acc = R_INC && !EMPTY;

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (WR_DATA),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (mem_rd_data)
  );

  // Pointer advance on accepted operations.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + P_SIZE'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + P_SIZE'(1);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (W_INC && FULL)  overflow_q <= 1'b1;
      else if (CLR_ERR)   overflow_q <= 1'b0;
      if (R_INC && EMPTY) underflow_q <= 1'b1;
      else if (CLR_ERR)   underflow_q <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented directly while the FIFO holds data.
    assign RD_DATA  = mem_rd_data;
    assign RD_VALID = !EMPTY;
  end else begin : g_reg_read
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Capture the head word on an accepted read; hold it otherwise.
    always_ff @(posedge CLK) begin
      if (RST) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rd_data;
      end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed self-checking bench for sync_fifo_flex (FWFT and registered-read instances).
module tb_sync_fifo_flex;

  localparam int unsigned DW = 8;
  localparam int unsigned PS = 4;

  logic          clk = 1'b0;
  logic          rst;

  logic          w_inc, r_inc, clr_err;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, afull, aempty, ovf, unf;
  logic [PS-1:0] level;

  logic          w_inc_r, r_inc_r, clr_err_r;
  logic [DW-1:0] wr_data_r;
  logic [DW-1:0] rd_data_r;
  logic          rd_valid_r, full_r, empty_r, afull_r, aempty_r, ovf_r, unf_r;
  logic [PS-1:0] level_r;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut (
    .CLK(clk), .RST(rst), .W_INC(w_inc), .WR_DATA(wr_data), .R_INC(r_inc),
    .CLR_ERR(clr_err), .RD_DATA(rd_data), .RD_VALID(rd_valid), .FULL(full),
    .EMPTY(empty), .ALMOST_FULL(afull), .ALMOST_EMPTY(aempty),
    .FILL_LEVEL(level), .OVERFLOW(ovf), .UNDERFLOW(unf)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut_r (
    .CLK(clk), .RST(rst), .W_INC(w_inc_r), .WR_DATA(wr_data_r), .R_INC(r_inc_r),
    .CLR_ERR(clr_err_r), .RD_DATA(rd_data_r), .RD_VALID(rd_valid_r), .FULL(full_r),
    .EMPTY(empty_r), .ALMOST_FULL(afull_r), .ALMOST_EMPTY(aempty_r),
    .FILL_LEVEL(level_r), .OVERFLOW(ovf_r), .UNDERFLOW(unf_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    w_inc = 0; r_inc = 0; clr_err = 0; wr_data = '0;
    w_inc_r = 0; r_inc_r = 0; clr_err_r = 0; wr_data_r = '0;
    step();
    rst = 1'b0;

    // Reset state
    check("rst_empty",  32'(empty),   32'd1);
    check("rst_full",   32'(full),    32'd0);
    check("rst_aempty", 32'(aempty),  32'd1);
    check("rst_afull",  32'(afull),   32'd0);
    check("rst_level",  32'(level),   32'd0);
    check("rst_ovf",    32'(ovf),     32'd0);
    check("rst_unf",    32'(unf),     32'd0);
    check("rst_valid",  32'(rd_valid), 32'd0);
    check("rst_r_valid", 32'(rd_valid_r), 32'd0);
    check("rst_r_data", 32'(rd_data_r), 32'd0);

    // 1: fill with 0x11..0x88, then overflow
    for (int i = 1; i <= 8; i++) begin
      w_inc = 1; wr_data = DW'(8'h11 * i);
      step();
      check("fill_level",  32'(level),  32'(i));
      check("fill_aempty", 32'(aempty), 32'(i <= 2));
      check("fill_afull",  32'(afull),  32'(i >= 6));
      check("fill_full",   32'(full),   32'(i == 8));
      if (i == 1) check("fwft_first", 32'(rd_data), 32'h11);
    end
    wr_data = 8'h99;
    step();
    w_inc = 0;
    check("ovf_set",   32'(ovf),   32'd1);
    check("ovf_level", 32'(level), 32'd8);

    // 2: drain in order, then underflow and clear
    for (int i = 1; i <= 8; i++) begin
      r_inc = 1;
      check("drain_data", 32'(rd_data), 32'(8'h11 * i));
      step();
    end
    r_inc = 0;
    check("drain_empty", 32'(empty), 32'd1);
    r_inc = 1;
    step();
    r_inc = 0;
    check("unf_set", 32'(unf),   32'd1);
    check("unf_lvl", 32'(level), 32'd0);
    clr_err = 1;
    step();
    clr_err = 0;
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_unf", 32'(unf), 32'd0);

    // 3: hold level 4 with simultaneous read/write across pointer wraps
    for (int i = 1; i <= 4; i++) begin
      w_inc = 1; wr_data = DW'(i);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      w_inc = 1; r_inc = 1; wr_data = DW'(k + 5);
      check("ss_data", 32'(rd_data), 32'(k + 1));
      step();
      check("ss_level", 32'(level), 32'd4);
    end
    w_inc = 0;
    for (int k = 20; k < 24; k++) begin
      check("ss_tail", 32'(rd_data), 32'(k + 1));
      step();
    end
    r_inc = 0;
    check("ss_empty", 32'(empty), 32'd1);

    // 4a: both at FULL -> read only, overflow
    for (int i = 0; i < 8; i++) begin
      w_inc = 1; wr_data = DW'(8'h30 + i);
      step();
    end
    r_inc = 1; wr_data = 8'hEE;
    check("bf_head", 32'(rd_data), 32'h30);
    step();
    w_inc = 0; r_inc = 0;
    check("bf_level", 32'(level), 32'd7);
    check("bf_ovf",   32'(ovf),   32'd1);
    check("bf_unf",   32'(unf),   32'd0);
    clr_err = 1;
    step();
    clr_err = 0;
    for (int i = 1; i < 8; i++) begin
      r_inc = 1;
      check("bf_drain", 32'(rd_data), 32'(8'h30 + i));
      step();
    end
    // 4b: both at EMPTY -> write only, underflow
    w_inc = 1; r_inc = 1; wr_data = 8'h77;
    step();
    w_inc = 0; r_inc = 0;
    check("be_level", 32'(level),   32'd1);
    check("be_unf",   32'(unf),     32'd1);
    check("be_ovf",   32'(ovf),     32'd0);
    check("be_data",  32'(rd_data), 32'h77);
    // set and clear coincide: set wins
    clr_err = 1; r_inc = 1;
    check("be_pop", 32'(rd_data), 32'h77);
    step();
    r_inc = 1;
    step();
    clr_err = 0; r_inc = 0;
    check("set_wins_unf", 32'(unf), 32'd1);
    clr_err = 1;
    step();
    clr_err = 0;
    check("clr2_unf", 32'(unf), 32'd0);

    // 5: registered-read instance
    w_inc_r = 1; wr_data_r = 8'hA5;
    step();
    wr_data_r = 8'h3C;
    step();
    w_inc_r = 0;
    check("rr_novalid", 32'(rd_valid_r), 32'd0);
    check("rr_level",   32'(level_r),    32'd2);
    r_inc_r = 1;
    step();
    check("rr_v1", 32'(rd_valid_r), 32'd1);
    check("rr_d1", 32'(rd_data_r),  32'hA5);
    step();
    r_inc_r = 0;
    check("rr_v2", 32'(rd_valid_r), 32'd1);
    check("rr_d2", 32'(rd_data_r),  32'h3C);
    step();
    check("rr_v3",   32'(rd_valid_r), 32'd0);
    check("rr_hold", 32'(rd_data_r),  32'h3C);

    // 6: reset mid-burst with W_INC high; errors set beforehand
    r_inc = 1;
    step();
    r_inc = 0;
    check("pre_unf", 32'(unf), 32'd1);
    for (int i = 0; i < 3; i++) begin
      w_inc = 1; wr_data = DW'(8'hC0 + i);
      step();
    end
    rst = 1;
    step();
    rst = 0; w_inc = 0;
    check("mr_level", 32'(level), 32'd0);
    check("mr_empty", 32'(empty), 32'd1);
    check("mr_unf",   32'(unf),   32'd0);
    check("mr_ovf",   32'(ovf),   32'd0);
    check("mr_r_data", 32'(rd_data_r), 32'd0);
    w_inc = 1; wr_data = 8'h5A;
    step();
    w_inc = 0;
    check("mr_level1", 32'(level),   32'd1);
    check("mr_data",   32'(rd_data), 32'h5A);
    r_inc = 1;
    step();
    r_inc = 0;
    check("mr_empty2", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
